rx_mf_decim: RTL and testbench

//  Receive-side matched filter: 21-tap symmetric SRRC FIR, same 11 unique coefficients as TX pulse shaper.

---
 rtl/rx_mf_decim_pkg.sv | 54 +++++
 rtl/rx_mf_decim_mac_serial.sv | 68 ++++++
 rtl/rx_mf_decim.sv | 144 ++++++++++++++
 tb/tb_rx_mf_decim.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_mf_decim_pkg.sv
// Shared receive/transmit pulse-shaping definitions.
//   - Tap counts and datapath widths for the 21-tap symmetric SRRC filter.
//   - Unique coefficient lookup (b[0..10], 0s18 signed; b[10] is the centre tap).
//   - 4-ASK Gray symbol codes and the slicer that maps a filtered value to a symbol.
//   - FSM state type for the serial matched filter.
package rx_mf_decim_pkg;

  localparam int NTAPS = 21;         // full filter length
  localparam int NUNIQ = 11;         // unique taps of the symmetric filter
  localparam int DW    = 18;         // sample / coefficient width
  localparam int PW    = DW + 1;     // pair-sum width (2s17)
  localparam int MW    = PW + DW;    // product width (2s35)
  localparam int AW    = 40;         // accumulator width
  localparam int IDXW  = 4;          // MAC index width (0..10 plus one past the end)

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  // 4-ASK Gray mapping, most negative level first.
  localparam logic [1:0] SYM_M3 = 2'b00;
  localparam logic [1:0] SYM_M1 = 2'b01;
  localparam logic [1:0] SYM_P1 = 2'b11;
  localparam logic [1:0] SYM_P3 = 2'b10;

  function automatic logic signed [DW-1:0] coef_at(input logic [IDXW-1:0] idx);
    case (idx)
      4'd0:    coef_at = 18'sd67;
      4'd1:    coef_at = 18'sd1261;
      4'd2:    coef_at = 18'sd1793;
      4'd3:    coef_at = -18'sd81;
      4'd4:    coef_at = -18'sd4311;
      4'd5:    coef_at = -18'sd7524;
      4'd6:    coef_at = -18'sd4326;
      4'd7:    coef_at = 18'sd8596;
      4'd8:    coef_at = 18'sd28599;
      4'd9:    coef_at = 18'sd47153;
      4'd10:   coef_at = 18'sd54721;
      default: coef_at = '0;
    endcase
  endfunction

  function automatic logic [1:0] slice_sym(input logic signed [DW-1:0] yv, input int thresh);
    int yi;
    yi = int'(yv);
    if (yi < -thresh)  slice_sym = SYM_M3;
    else if (yi < 0)   slice_sym = SYM_M1;
    else if (yi < thresh) slice_sym = SYM_P1;
    else               slice_sym = SYM_P3;
  endfunction

endpackage

// File: rtl/rx_mf_decim_mac_serial.sv
// Serial multiply-accumulate engine for the symmetric matched filter.
// On load it snapshots the folded pair sums p[i] = x[i] + x[20-i] (p[10] = x[10]),
// clears the accumulator and index; each step then adds p[idx]*b[idx] and advances idx.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   load        capture pair sums from win, clear acc/idx
//   step        perform one multiply-accumulate
//   win         current 21-sample window (x[0] newest)
//   y_next      acc[35:18], the filter output in 1s17 (floor)
//   last        the step being taken this cycle is the final (centre) tap
module rx_mf_decim_mac_serial
  import rx_mf_decim_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic signed [DW-1:0] win [NTAPS],
  output logic signed [DW-1:0] y_next,
  output logic                 last
);

  logic signed [PW-1:0]  p_q [NUNIQ];
  logic signed [PW-1:0]  p_d [NUNIQ];
  logic [IDXW-1:0]       idx_q, idx_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic signed [PW-1:0]  p_sel;
  logic signed [DW-1:0]  c_sel;
  logic signed [MW-1:0]  prod;

  always_comb begin
    p_d   = p_q;
    idx_d = idx_q;
    acc_d = acc_q;
    p_sel = (idx_q < IDXW'(NUNIQ)) ? p_q[idx_q] : '0;
    c_sel = coef_at(idx_q);
    // Both operands are signed, so the sized casts sign-extend before multiplying.
    prod  = MW'(p_sel) * MW'(c_sel);
    if (load) begin
      for (int i = 0; i < NUNIQ - 1; i++) begin
        p_d[i] = PW'(win[i]) + PW'(win[NTAPS-1-i]);
      end
      p_d[NUNIQ-1] = PW'(win[NUNIQ-1]);
      idx_d = '0;
      acc_d = '0;
    end else if (step) begin
      acc_d = acc_q + AW'(prod);
      idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_q   <= '{default: '0};
      idx_q <= '0;
      acc_q <= '0;
    end else begin
      p_q   <= p_d;
      idx_q <= idx_d;
      acc_q <= acc_d;
    end
  end

  // Sum of |b| over all taps is below 2^18, so |acc| < 2^35 and bits [35:18] never wrap.
  assign y_next = acc_q[35:18];
  assign last   = (idx_q == IDXW'(NUNIQ - 1));

endmodule

// File: rtl/rx_mf_decim.sv
// Receive matched filter with symbol-rate decimation and 4-ASK slicing.
// Samples shift into a 21-deep window; one decision is started per symbol at
// SAMPLE_PHASE and computed serially (IDLE -> MAC x11 -> OUT).
// Interface semantics: in_valid is a one-cycle strobe with no backpressure; a sample
// is consumed on every cycle in_valid is high. A decision start that arrives while a
// start is pending or the FSM is not IDLE is dropped and sets the sticky overrun flag.
// out_valid pulses for one cycle when y/sym_out update; y/sym_out hold otherwise.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   in_valid    x_in valid this cycle
//   x_in        received sample, signed 1s17
//   y           filter output at the symbol instant, signed 1s17
//   sym_out     sliced Gray-coded symbol
//   out_valid   one-cycle update pulse
//   busy        FSM not IDLE or start pending
//   overrun     sticky dropped-start flag
module rx_mf_decim
  import rx_mf_decim_pkg::*;
#(
  parameter int DECIM        = 4,
  parameter int SAMPLE_PHASE = 0,
  parameter int THRESH       = 32768
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] x_in,
  output logic signed [DW-1:0] y,
  output logic [1:0]           sym_out,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 overrun
);

  localparam int PHW = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic signed [DW-1:0] x_q [NTAPS];
  logic signed [DW-1:0] x_d [NTAPS];
  logic [PHW-1:0]       phase_q, phase_d;
  logic                 start_pend_q, start_pend_d;
  logic                 overrun_q, overrun_d;
  state_e               state_q, state_d;
  logic signed [DW-1:0] y_q, y_d;
  logic [1:0]           sym_q, sym_d;
  logic                 out_valid_q, out_valid_d;

  logic                 start_req;
  logic                 busy_now;
  logic                 mac_load;
  logic                 mac_step;
  logic                 mac_last;
  logic signed [DW-1:0] mac_y;

  rx_mf_decim_mac_serial u_mac (
    .clk    (clk),
    .reset  (reset),
    .load   (mac_load),
    .step   (mac_step),
    .win    (x_q),
    .y_next (mac_y),
    .last   (mac_last)
  );

  always_comb begin
    x_d          = x_q;
    phase_d      = phase_q;
    start_pend_d = start_pend_q;
    overrun_d    = overrun_q;
    state_d      = state_q;
    y_d          = y_q;
    sym_d        = sym_q;
    out_valid_d  = 1'b0;
    mac_load     = 1'b0;
    mac_step     = 1'b0;

    // Phase compare uses the pre-increment phase of the sample being accepted.
    start_req = in_valid && (phase_q == PHW'(SAMPLE_PHASE));
    busy_now  = start_pend_q || (state_q != ST_IDLE);

    if (in_valid) begin
      x_d[0] = x_in;
      for (int k = 1; k < NTAPS; k++) begin
        x_d[k] = x_q[k-1];
      end
      phase_d = (phase_q == PHW'(DECIM - 1)) ? '0 : phase_q + 1'b1;
    end

    if (start_req) begin
      if (busy_now) overrun_d    = 1'b1;
      else          start_pend_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_pend_q) begin
          // Snapshot decouples the computation from the still-shifting window.
          mac_load     = 1'b1;
          start_pend_d = 1'b0;
          state_d      = ST_MAC;
        end
      end
      ST_MAC: begin
        mac_step = 1'b1;
        if (mac_last) state_d = ST_OUT;
      end
      ST_OUT: begin
        y_d         = mac_y;
        sym_d       = slice_sym(mac_y, THRESH);
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q          <= '{default: '0};
      phase_q      <= '0;
      start_pend_q <= 1'b0;
      overrun_q    <= 1'b0;
      state_q      <= ST_IDLE;
      y_q          <= '0;
      sym_q        <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      x_q          <= x_d;
      phase_q      <= phase_d;
      start_pend_q <= start_pend_d;
      overrun_q    <= overrun_d;
      state_q      <= state_d;
      y_q          <= y_d;
      sym_q        <= sym_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign y         = y_q;
  assign sym_out   = sym_q;
  assign out_valid = out_valid_q;
  assign busy      = start_pend_q || (state_q != ST_IDLE);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_rx_mf_decim.sv
// Bench for rx_mf_decim: two instances (SAMPLE_PHASE 0 and 2) share stimulus;
// a behavioural model pushes expected decisions when a start is accepted and a
// negedge monitor pops and compares them when out_valid pulses.
module tb_rx_mf_decim;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset    = 1'b1;
  logic               in_valid = 1'b0;
  logic signed [17:0] x_in     = '0;

  logic signed [17:0] y0, y1;
  logic [1:0]         sym0, sym1;
  logic               ov0, ov1, busy0, busy1, ovr0, ovr1;

  rx_mf_decim #(.DECIM(4), .SAMPLE_PHASE(0), .THRESH(32768)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .x_in(x_in),
    .y(y0), .sym_out(sym0), .out_valid(ov0), .busy(busy0), .overrun(ovr0)
  );

  rx_mf_decim #(.DECIM(4), .SAMPLE_PHASE(2), .THRESH(32768)) dut_p2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .x_in(x_in),
    .y(y1), .sym_out(sym1), .out_valid(ov1), .busy(busy1), .overrun(ovr1)
  );

  // ---------------- model state ----------------
  int         uniq [11] = '{67, 1261, 1793, -81, -4311, -7524, -4326, 8596, 28599, 47153, 54721};
  int         sp_of [2] = '{0, 2};
  longint     hist [2][21];
  int         ph [2];
  int         last_acc [2];
  bit         has_acc [2];
  bit         ovr_exp [2];
  logic [51:0] exp_q0[$];   // {start_edge[31:0], sym[1:0], y[17:0]}
  logic [51:0] exp_q1[$];
  int         edge_n = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_out0 = 0;
  int         n_out1 = 0;
  logic [51:0] e0, e1;
  int         lat0, lat1;

  function automatic logic [1:0] ref_slice(input longint v);
    if (v < -32768)     return 2'b00;
    else if (v < 0)     return 2'b01;
    else if (v < 32768) return 2'b11;
    else                return 2'b10;
  endfunction

  function automatic int coef_k(input int k);
    return (k <= 10) ? uniq[k] : uniq[20-k];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 21; k++) hist[i][k] = 0;
      ph[i] = 0; last_acc[i] = 0; has_acc[i] = 0; ovr_exp[i] = 0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic model_edge(input bit v, input longint x);
    for (int i = 0; i < 2; i++) begin
      bit          req;
      longint      acc;
      longint      yv;
      logic [51:0] ent;
      req = v && (ph[i] == sp_of[i]);
      if (v) begin
        for (int k = 20; k > 0; k--) hist[i][k] = hist[i][k-1];
        hist[i][0] = x;
        ph[i] = (ph[i] == 3) ? 0 : ph[i] + 1;
      end
      if (req) begin
        if (!has_acc[i] || (edge_n - last_acc[i] >= 14)) begin
          acc = 0;
          for (int k = 0; k < 21; k++) acc += hist[i][k] * longint'(coef_k(k));
          yv  = acc >>> 18;
          ent = {32'(edge_n), ref_slice(yv), 18'(yv)};
          if (i == 0) exp_q0.push_back(ent);
          else        exp_q1.push_back(ent);
          has_acc[i]  = 1;
          last_acc[i] = edge_n;
        end else begin
          ovr_exp[i] = 1;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input logic signed [17:0] x);
    in_valid = v;
    x_in     = x;
    @(posedge clk);
    edge_n++;
    model_edge(v, longint'(x));
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    x_in     = '0;
    @(posedge clk);
    edge_n++;
    model_clear();
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 60; c++) begin
      if (exp_q0.size() == 0 && exp_q1.size() == 0) break;
      drive(1'b0, 18'sd0);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (ov0 === 1'b1) begin
      n_out0++;
      n_cmp++;
      if (exp_q0.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out0 got y=%0d sym=%b, no decision expected", y0, sym0);
      end else begin
        e0 = exp_q0.pop_front();
        lat0 = edge_n + 1 - int'(e0[51:20]);
        if (y0 !== e0[17:0]) begin
          n_bad++;
          $display("FAIL out0_y got=%0d exp=%0d", y0, $signed(e0[17:0]));
        end
        n_cmp++;
        if (sym0 !== e0[19:18]) begin
          n_bad++;
          $display("FAIL out0_sym got=%b exp=%b", sym0, e0[19:18]);
        end
        n_cmp++;
        if (lat0 != 14) begin
          n_bad++;
          $display("FAIL out0_latency got=%0d exp=14", lat0);
        end
      end
    end
    if (ov1 === 1'b1) begin
      n_out1++;
      n_cmp++;
      if (exp_q1.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out1 got y=%0d sym=%b, no decision expected", y1, sym1);
      end else begin
        e1 = exp_q1.pop_front();
        lat1 = edge_n + 1 - int'(e1[51:20]);
        if (y1 !== e1[17:0]) begin
          n_bad++;
          $display("FAIL out1_y got=%0d exp=%0d", y1, $signed(e1[17:0]));
        end
        n_cmp++;
        if (sym1 !== e1[19:18]) begin
          n_bad++;
          $display("FAIL out1_sym got=%b exp=%b", sym1, e1[19:18]);
        end
        n_cmp++;
        if (lat1 != 14) begin
          n_bad++;
          $display("FAIL out1_latency got=%0d exp=14", lat1);
        end
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (y0 !== 18'sd0) begin n_bad++; $display("FAIL reset_y got=%0d exp=0", y0); end
    n_cmp++;
    if (sym0 !== 2'b00) begin n_bad++; $display("FAIL reset_sym got=%b exp=00", sym0); end
    n_cmp++;
    if (ov0 !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", ov0); end
    n_cmp++;
    if (busy0 !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy0); end
    n_cmp++;
    if (ovr0 !== 1'b0) begin n_bad++; $display("FAIL reset_overrun got=%b exp=0", ovr0); end
  endtask

  task automatic test_impulse();
    int start_e;
    bit got;
    bit v;
    start_e = -1;
    got     = 0;
    do_reset();
    // Impulse at phase 2 lands on x[10] for the decision started 10 samples later.
    for (int c = 0; c < 160; c++) begin
      v = (c % 4 == 0);
      drive(v, (v && (c / 4) == 2) ? 18'sd131071 : 18'sd0);
      if (v && (c / 4) == 12) start_e = edge_n;
      if (start_e >= 0 && !got && ov0) begin
        got = 1;
        n_cmp++;
        if (edge_n + 1 - start_e != 14) begin
          n_bad++;
          $display("FAIL impulse_latency got=%0d exp=14", edge_n + 1 - start_e);
        end
        n_cmp++;
        if (y0 !== 18'sd27360) begin n_bad++; $display("FAIL impulse_y got=%0d exp=27360", y0); end
        n_cmp++;
        if (sym0 !== 2'b11) begin n_bad++; $display("FAIL impulse_sym got=%b exp=11", sym0); end
      end
    end
    n_cmp++;
    if (!got) begin n_bad++; $display("FAIL impulse_timeout got=no out_valid exp=out_valid"); end
    wait_drain();
    n_cmp++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      n_bad++;
      $display("FAIL impulse_drain got=%0d/%0d pending exp=0/0", exp_q0.size(), exp_q1.size());
    end
  endtask

  task automatic test_dc();
    logic signed [17:0] lvl [3];
    logic signed [17:0] exp_y [3];
    logic [1:0]         exp_s [3];
    lvl   = '{18'sd65536, -18'sd65536, 18'sd0};
    exp_y = '{18'sd49293, -18'sd49294, 18'sd0};
    exp_s = '{2'b10, 2'b00, 2'b11};
    do_reset();
    for (int t = 0; t < 3; t++) begin
      for (int s = 0; s < 28; s++) begin
        drive(1'b1, lvl[t]);
        repeat (3) drive(1'b0, 18'sd0);
      end
      wait_drain();
      repeat (10) drive(1'b0, 18'sd0);
      n_cmp++;
      if (y0 !== exp_y[t]) begin n_bad++; $display("FAIL dc%0d_y got=%0d exp=%0d", t, y0, exp_y[t]); end
      n_cmp++;
      if (sym0 !== exp_s[t]) begin n_bad++; $display("FAIL dc%0d_sym got=%b exp=%b", t, sym0, exp_s[t]); end
      n_cmp++;
      if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
        n_bad++;
        $display("FAIL dc%0d_drain got=%0d/%0d pending exp=0/0", t, exp_q0.size(), exp_q1.size());
      end
    end
  endtask

  task automatic test_back_to_back();
    logic signed [17:0] xr;
    int base0;
    base0 = n_out0;
    do_reset();
    for (int s = 0; s < 40; s++) begin
      xr = 18'($urandom_range(0, 262143));
      drive(1'b1, xr);
      if (s == 3) begin
        n_cmp++;
        if (ovr0 !== 1'b0) begin n_bad++; $display("FAIL overrun_before_2nd got=%b exp=0", ovr0); end
      end
      if (s == 4) begin
        n_cmp++;
        if (ovr0 !== 1'b1) begin n_bad++; $display("FAIL overrun_after_2nd got=%b exp=1", ovr0); end
      end
    end
    wait_drain();
    n_cmp++;
    if (ovr0 !== ovr_exp[0]) begin n_bad++; $display("FAIL overrun0_final got=%b exp=%b", ovr0, ovr_exp[0]); end
    n_cmp++;
    if (ovr1 !== ovr_exp[1]) begin n_bad++; $display("FAIL overrun1_final got=%b exp=%b", ovr1, ovr_exp[1]); end
    n_cmp++;
    if (n_out0 - base0 != 3) begin n_bad++; $display("FAIL b2b_decisions got=%0d exp=3", n_out0 - base0); end
    n_cmp++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_drain got=%0d/%0d pending exp=0/0", exp_q0.size(), exp_q1.size());
    end
  endtask

  task automatic test_reset_mid_mac();
    int base0;
    // Phase is back at 0 after the 40 samples of the previous test.
    drive(1'b1, 18'sd20000);
    repeat (4) drive(1'b0, 18'sd0);
    n_cmp++;
    if (busy0 !== 1'b1) begin n_bad++; $display("FAIL midmac_busy_before got=%b exp=1", busy0); end
    do_reset();
    n_cmp++;
    if (ov0 !== 1'b0) begin n_bad++; $display("FAIL midmac_out_valid got=%b exp=0", ov0); end
    n_cmp++;
    if (y0 !== 18'sd0) begin n_bad++; $display("FAIL midmac_y got=%0d exp=0", y0); end
    n_cmp++;
    if (sym0 !== 2'b00) begin n_bad++; $display("FAIL midmac_sym got=%b exp=00", sym0); end
    n_cmp++;
    if (busy0 !== 1'b0) begin n_bad++; $display("FAIL midmac_busy got=%b exp=0", busy0); end
    n_cmp++;
    if (ovr0 !== 1'b0) begin n_bad++; $display("FAIL midmac_overrun got=%b exp=0", ovr0); end
    repeat (20) drive(1'b0, 18'sd0);
    base0 = n_out0;
    drive(1'b1, 18'sd30000);
    repeat (3) drive(1'b0, 18'sd0);
    wait_drain();
    n_cmp++;
    if (n_out0 - base0 != 1) begin n_bad++; $display("FAIL midmac_restart_count got=%0d exp=1", n_out0 - base0); end
    // Only x[0]=30000 in the window: 30000*67 >> 18 = 7.
    n_cmp++;
    if (y0 !== 18'sd7) begin n_bad++; $display("FAIL midmac_restart_y got=%0d exp=7", y0); end
    n_cmp++;
    if (sym0 !== 2'b11) begin n_bad++; $display("FAIL midmac_restart_sym got=%b exp=11", sym0); end
  endtask

  task automatic test_phase();
    int base0;
    int base1;
    do_reset();
    base0 = n_out0;
    base1 = n_out1;
    for (int s = 0; s < 48; s++) begin
      drive(1'b1, 18'(-30000 + s * 1300));
      repeat (3) drive(1'b0, 18'sd0);
    end
    wait_drain();
    n_cmp++;
    if (n_out1 - base1 != 12) begin n_bad++; $display("FAIL phase2_count got=%0d exp=12", n_out1 - base1); end
    n_cmp++;
    if (n_out0 - base0 != 12) begin n_bad++; $display("FAIL phase0_count got=%0d exp=12", n_out0 - base0); end
    n_cmp++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      n_bad++;
      $display("FAIL phase_drain got=%0d/%0d pending exp=0/0", exp_q0.size(), exp_q1.size());
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_impulse();
    test_dc();
    test_back_to_back();
    test_reset_mid_mac();
    test_phase();
    repeat (3) drive(1'b0, 18'sd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
